// File: rtl/lsu_mem_port_if.sv
// Request/response/RAM bundle for the load/store unit memory port.
// The slave modport is the LSU; the master side is the core plus the data RAM.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_w_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_w_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store memory port: one request at a time, sub-word loads extended, sub-word stores via RMW.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of accessing RAM.
module lsu_mem_port (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_port_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_w_en_q, mem_w_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        req_err;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = (bus.req_size == 2'b11)
                 || ((bus.req_size == 2'b01) && bus.req_addr[0])
                 || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign req_err = (bus.req_size == 2'b11);
`endif

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] res;
    case (size)
      2'b00:   res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size);
    logic [31:0] res;
    case (size)
      2'b00:   res = {old[31:8], wd[7:0]};
      2'b01:   res = {old[31:16], wd[15:0]};
      default: res = wd;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_w_en_d   = 1'b0;
    mem_wdata_d  = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (!bus.req_we || (bus.req_size != 2'b10)) begin
            state_d = RD;
          end else begin
            // Full-word stores skip the read; the RAM writes whole blocks anyway.
            state_d     = WR;
            mem_w_en_d  = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end
        end
      end
      RD: begin
        if (!we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = extend(bus.mem_rdata, size_q, uns_q);
        end else begin
          state_d     = WR;
          mem_w_en_d  = 1'b1;
          mem_wdata_d = merge(bus.mem_rdata, wdata_q, size_q);
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_w_en_q   <= 1'b0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  // Reset arriving during WR must suppress the write on that same edge.
  assign bus.mem_w_en   = mem_w_en_q & ~rst;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 256-byte little-endian RAM model.
// Expected values track LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_port_if ifc ();

  lsu_mem_port dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [7:0] ram [256];
  logic [7:0] ra;

  always_comb begin
    ra = ifc.mem_addr[7:0];
    ifc.mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
  end

  always @(posedge clk) begin
    if (ifc.mem_w_en) begin
      ram[ifc.mem_addr[7:0]]         <= ifc.mem_wdata[7:0];
      ram[ifc.mem_addr[7:0] + 8'd1]  <= ifc.mem_wdata[15:8];
      ram[ifc.mem_addr[7:0] + 8'd2]  <= ifc.mem_wdata[23:16];
      ram[ifc.mem_addr[7:0] + 8'd3]  <= ifc.mem_wdata[31:24];
    end
  end

  int vec  = 0;
  int errs = 0;

  int          lat, np, nwr, wrk;
  logic [31:0] rd, wa, wd;
  logic        er;

  // Issue one request, then watch `window` cycles; k=0 is the cycle right after acceptance.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int window);
    bit seen;
    lat = -1; np = 0; nwr = 0; wrk = -1; rd = 32'd0; wa = 32'd0; wd = 32'd0; er = 1'b0;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = we; ifc.req_size = size;
    ifc.req_unsigned = uns; ifc.req_addr = addr; ifc.req_wdata = wdata;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.req_ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    vec++;
    if (!seen) begin
      errs++;
      $display("FAIL accept_timeout: req_ready got 0 want 1 within 20 cycles");
      ifc.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0; ifc.req_we = ~we; ifc.req_size = ~size;
    ifc.req_unsigned = ~uns; ifc.req_addr = 32'hFFFF_FFF0; ifc.req_wdata = 32'h5A5A_5A5A;
    for (int k = 0; k < window; k++) begin
      @(negedge clk);
      if (ifc.mem_w_en) begin
        nwr++;
        if (wrk < 0) begin wrk = k; wa = ifc.mem_addr; wd = ifc.mem_wdata; end
      end
      if (ifc.resp_valid) begin
        np++;
        if (lat < 0) begin lat = k; rd = ifc.resp_rdata; er = ifc.resp_err; end
      end
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d pulses=%0d rdata=%h err=%0d writes=%0d wdata_out=%h",
             we, size, uns, addr, wdata, lat, np, rd, er, nwr, wd);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (ifc.req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", ifc.req_ready); end
    vec++; if (ifc.resp_valid !== 1'b0) begin errs++; $display("FAIL rst_resp_valid: got %b want 0", ifc.resp_valid); end
    vec++; if (ifc.resp_err !== 1'b0) begin errs++; $display("FAIL rst_resp_err: got %b want 0", ifc.resp_err); end
    vec++; if (ifc.resp_rdata !== 32'd0) begin errs++; $display("FAIL rst_rdata: got %h want 0", ifc.resp_rdata); end
    vec++; if (ifc.mem_w_en !== 1'b0) begin errs++; $display("FAIL rst_w_en: got %b want 0", ifc.mem_w_en); end
    vec++; if (ifc.mem_addr !== 32'd0) begin errs++; $display("FAIL rst_addr: got %h want 0", ifc.mem_addr); end
    vec++; if (ifc.mem_wdata !== 32'd0) begin errs++; $display("FAIL rst_wdata: got %h want 0", ifc.mem_wdata); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (ifc.req_ready !== 1'b1) begin errs++; $display("FAIL post_rst_ready: got %b want 1", ifc.req_ready); end
    $display("txn reset released");
  endtask

  task automatic test_load_word;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    vec++; if (lat !== 1) begin errs++; $display("FAIL lw_latency: got %0d want 1", lat); end
    vec++; if (np !== 1) begin errs++; $display("FAIL lw_pulses: got %0d want 1", np); end
    vec++; if (rd !== 32'h1122_3344) begin errs++; $display("FAIL lw_rdata: got %h want 11223344", rd); end
    vec++; if (er !== 1'b0) begin errs++; $display("FAIL lw_err: got %b want 0", er); end
    vec++; if (nwr !== 0) begin errs++; $display("FAIL lw_writes: got %0d want 0", nwr); end
    vec++; if (ifc.resp_rdata !== 32'h1122_3344) begin errs++; $display("FAIL lw_rdata_hold: got %h want 11223344", ifc.resp_rdata); end
  endtask

  task automatic test_misaligned;
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 5);
`ifdef LSU_MISALIGN_TRAP_EN
    vec++; if (lat !== 0) begin errs++; $display("FAIL lh_mis_latency: got %0d want 0", lat); end
    vec++; if (er !== 1'b1) begin errs++; $display("FAIL lh_mis_err: got %b want 1", er); end
    vec++; if (rd !== 32'd0) begin errs++; $display("FAIL lh_mis_rdata: got %h want 0", rd); end
`else
    vec++; if (lat !== 1) begin errs++; $display("FAIL lh_mis_latency: got %0d want 1", lat); end
    vec++; if (er !== 1'b0) begin errs++; $display("FAIL lh_mis_err: got %b want 0", er); end
    vec++; if (rd !== 32'h0000_2233) begin errs++; $display("FAIL lh_mis_rdata: got %h want 00002233", rd); end
`endif
    vec++; if (nwr !== 0) begin errs++; $display("FAIL lh_mis_writes: got %0d want 0", nwr); end
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5);
`ifdef LSU_MISALIGN_TRAP_EN
    vec++; if (er !== 1'b1) begin errs++; $display("FAIL lw_mis_err: got %b want 1", er); end
`else
    vec++; if (rd !== 32'h5511_2233) begin errs++; $display("FAIL lw_mis_rdata: got %h want 55112233", rd); end
`endif
  endtask

  task automatic test_store_byte;
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEAB, 5);
    vec++; if (lat !== 2) begin errs++; $display("FAIL sb_latency: got %0d want 2", lat); end
    vec++; if (np !== 1) begin errs++; $display("FAIL sb_pulses: got %0d want 1", np); end
    vec++; if (rd !== 32'd0 || er !== 1'b0) begin errs++; $display("FAIL sb_resp: got rdata=%h err=%b want 0/0", rd, er); end
    vec++; if (nwr !== 1 || wrk !== 1) begin errs++; $display("FAIL sb_write_cycle: got n=%0d k=%0d want 1/1", nwr, wrk); end
    vec++; if (wa !== 32'h10) begin errs++; $display("FAIL sb_addr: got %h want 00000010", wa); end
    vec++; if (wd !== 32'h1122_33AB) begin errs++; $display("FAIL sb_wdata: got %h want 112233ab", wd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    vec++; if (rd !== 32'h1122_33AB) begin errs++; $display("FAIL sb_readback: got %h want 112233ab", rd); end
  endtask

  task automatic test_store_half;
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_8000, 5);
    vec++; if (lat !== 2) begin errs++; $display("FAIL sh_latency: got %0d want 2", lat); end
    vec++; if (wrk !== 1 || wa !== 32'h12) begin errs++; $display("FAIL sh_write: got k=%0d addr=%h want 1/00000012", wrk, wa); end
    vec++; if (wd !== 32'h6655_8000) begin errs++; $display("FAIL sh_wdata: got %h want 66558000", wd); end
  endtask

  task automatic test_sign_extend;
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 4);
    vec++; if (rd !== 32'hFFFF_FF80) begin errs++; $display("FAIL lb: got %h want ffffff80", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4);
    vec++; if (rd !== 32'h0000_0080) begin errs++; $display("FAIL lbu: got %h want 00000080", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 4);
    vec++; if (rd !== 32'hFFFF_8000) begin errs++; $display("FAIL lh: got %h want ffff8000", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 4);
    vec++; if (rd !== 32'h0000_8000) begin errs++; $display("FAIL lhu: got %h want 00008000", rd); end
  endtask

  task automatic test_word_store;
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 5);
    vec++; if (lat !== 1) begin errs++; $display("FAIL sw_latency: got %0d want 1", lat); end
    vec++; if (nwr !== 1 || wrk !== 0) begin errs++; $display("FAIL sw_write_cycle: got n=%0d k=%0d want 1/0", nwr, wrk); end
    vec++; if (wd !== 32'h1234_5678 || wa !== 32'h40) begin errs++; $display("FAIL sw_write: got %h@%h want 12345678@00000040", wd, wa); end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 4);
    vec++; if (rd !== 32'h1234_5678) begin errs++; $display("FAIL sw_readback: got %h want 12345678", rd); end
  endtask

  task automatic test_error;
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 4);
    vec++; if (lat !== 0 || np !== 1) begin errs++; $display("FAIL err_ld_timing: got lat=%0d n=%0d want 0/1", lat, np); end
    vec++; if (er !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL err_ld_resp: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, 4);
    vec++; if (er !== 1'b1 || nwr !== 0) begin errs++; $display("FAIL err_st: got err=%b writes=%0d want 1/0", er, nwr); end
  endtask

  task automatic test_reset_during_write;
    int pulses;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_size = 2'b10;
    ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h20; ifc.req_wdata = 32'hCAFE_F00D;
    vec++; if (ifc.req_ready !== 1'b1) begin errs++; $display("FAIL rstwr_idle: got ready=%b want 1", ifc.req_ready); end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vec++; if (ifc.mem_w_en !== 1'b0) begin errs++; $display("FAIL rstwr_w_en: got %b want 0", ifc.mem_w_en); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (ifc.req_ready !== 1'b1) begin errs++; $display("FAIL rstwr_ready: got %b want 1", ifc.req_ready); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (ifc.resp_valid) pulses++;
      @(negedge clk);
    end
    vec++; if (pulses !== 0) begin errs++; $display("FAIL rstwr_no_resp: got %0d pulses want 0", pulses); end
    vec++; if ({ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]} !== 32'h0102_0304) begin
      errs++; $display("FAIL rstwr_ram: got %h want 01020304", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]});
    end
    $display("txn sw 0x20 aborted by reset, pulses=%0d", pulses);
  endtask

  task automatic test_back_to_back;
    logic [4:0]  ready_seen;
    logic [6:0]  pulse_seen;
    logic [31:0] d1, d2;
    ready_seen = '0; pulse_seen = '0; d1 = '0; d2 = '0;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_size = 2'b10;
    ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h10; ifc.req_wdata = 32'h0;
    @(posedge clk); #1;
    ifc.req_size = 2'b00; ifc.req_unsigned = 1'b1; ifc.req_addr = 32'h14;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) ready_seen[k] = ifc.req_ready;
      pulse_seen[k] = ifc.resp_valid;
      if (k == 1) d1 = ifc.resp_rdata;
      if (k == 4) d2 = ifc.resp_rdata;
      if (k == 2) begin @(posedge clk); #1 ifc.req_valid = 1'b0; end
    end
    vec++; if (ready_seen !== 5'b00100) begin errs++; $display("FAIL b2b_ready: got %b want 00100", ready_seen); end
    vec++; if (pulse_seen !== 7'b0010010) begin errs++; $display("FAIL b2b_pulses: got %b want 0010010", pulse_seen); end
    vec++; if (d1 !== 32'h8000_33AB) begin errs++; $display("FAIL b2b_first: got %h want 800033ab", d1); end
    vec++; if (d2 !== 32'h0000_0055) begin errs++; $display("FAIL b2b_second: got %h want 00000055", d2); end
    $display("txn back-to-back loads ready=%b pulses=%b d1=%h d2=%h", ready_seen, pulse_seen, d1, d2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'h44; ram[8'h11] = 8'h33; ram[8'h12] = 8'h22; ram[8'h13] = 8'h11;
    ram[8'h14] = 8'h55; ram[8'h15] = 8'h66; ram[8'h16] = 8'h77; ram[8'h17] = 8'h88;
    ram[8'h20] = 8'h04; ram[8'h21] = 8'h03; ram[8'h22] = 8'h02; ram[8'h23] = 8'h01;
    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 2'b00;
    ifc.req_unsigned = 1'b0; ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0;

    test_reset();
    test_load_word();
    test_misaligned();
    test_store_byte();
    test_store_half();
    test_sign_extend();
    test_word_store();
    test_error();
    test_reset_during_write();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit memory port: sits between the core's execute stage and the byte-addressed 4B-block data RAM. Accepts one load or store request at a time, drives the RAM's read/write port, sign/zero-extends byte and halfword loads, and performs read-modify-write for byte and halfword stores, since the RAM only writes full 4B blocks. Returns a single-cycle response pulse to the core.

## Interface
Parameters:
- none; address and data widths are fixed at 32.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and accepting; a request is accepted when `req_valid && req_ready` at posedge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low bytes used for sub-word sizes.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; holds until next response.
- `resp_err`  out  1  request rejected; valid with `resp_valid`.
- `mem_w_en`  out  1  RAM write enable.
- `mem_addr`  out  32  RAM byte address (block = bytes addr..addr+3, little-endian).
- `mem_wdata`  out  32  RAM write data.
- `mem_rdata`  in  32  RAM combinational read data for `mem_addr`.

## Operation
- Request fields are latched on acceptance; the inputs are don't-care afterwards.
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1, no memory activity. On acceptance:
  - error → RESP with err=1;
  - load → RD;
  - word store → WR;
  - byte/half store → RD.
- RD: `mem_addr`=latched addr, `mem_w_en`=0. `mem_rdata` is captured at posedge.
  - load → RESP; `resp_rdata` = extracted and extended low byte/half/word.
  - store → WR.
- WR: `mem_addr`=latched addr, `mem_w_en`=1.
  - `mem_wdata`: word = wdata; half = {captured[31:16], wdata[15:0]}; byte = {captured[31:8], wdata[7:0]}.
  - Next state RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. No response backpressure.
- Error conditions: `req_size`=11 always. Misalignment is errored as defined under Configuration.
- Error responses: no RAM access, `resp_rdata`=0, `resp_err`=1.
- Store responses: `resp_rdata`=0, `resp_err`=0.
- Outside RD/WR: `mem_w_en`=0, `mem_addr`=latched addr, `mem_wdata`=0.
- `mem_w_en` is gated by `!rst`: a reset asserted during WR must not write.

## Timing
- Reset: state IDLE. `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_w_en`=0, `mem_addr`=0, `mem_wdata`=0. Latched request registers are cleared.
- Acceptance at edge T (state IDLE during cycle T-1). `resp_valid` is high during cycle:
  - error: T (1 cycle after accept);
  - load, word store: T+1;
  - sub-word store: T+2.
- RAM write commits at the posedge ending the WR cycle.
- `req_ready`=0 from the cycle after acceptance through the RESP cycle. The next request can be accepted at the edge ending RESP+1 (IDLE). Peak throughput is one load every 3 cycles.
- Reset mid-operation: the next cycle is IDLE and no response is produced for the aborted request.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a half access with addr[0]≠0, or a word access with addr[1:0]≠0, returns `resp_err`=1 without touching RAM.
  - Undefined: these accesses are performed at the raw byte address, using the RAM's native unaligned block access; only `req_size`=11 errors.

## Test plan
- RAM bytes 0x10..0x13 = 44,33,22,11; lw 0x10 → `resp_valid` 2 cycles after accept, `resp_rdata`=0x11223344, `resp_err`=0.
- sb 0x10, wdata 0xDEADBEAB → `mem_w_en` one cycle with `mem_wdata`=0x112233AB, addr 0x10; a following lw 0x10 returns 0x112233AB; store response 3 cycles after accept.
- Byte 0x80 at 0x13: lb → 0xFFFFFF80; lbu → 0x00000080; lh 0x12 (bytes 0x00,0x80) → 0xFFFF8000.
- lh 0x11:
  - macro defined → `resp_err`=1 one cycle after accept, `mem_w_en` never high;
  - macro undefined → 0x00002233.
- sw 0x20 wdata 0xCAFEF00D, `rst` asserted during the WR cycle → `mem_w_en`=0, RAM at 0x20 unchanged, `req_ready`=1 next cycle, no `resp_valid`.
- `req_valid` held high with two loads → the second is accepted only after the first RESP; `resp_valid` pulses once per request; `req_size`=11 → `resp_err`=1.
